// File: rtl/axi4_lite_slave_mem.sv
// AXI4-Lite responder backed by a word-addressed RAM: byte-strobed writes with AW/W in any order,
// wait-stated reads, SLVERR for addresses beyond the RAM, and a saturating count of error responses.
module axi4_lite_slave_mem #(
    parameter int ADDRESS_WIDTH  = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 256,
    parameter int READ_WAIT      = 0
) (
    input  logic                        axi4_lite_aclk,
    input  logic                        axi4_lite_aresetn,
    input  logic [ADDRESS_WIDTH-1:0]    awaddr,
    input  logic [2:0]                  awprot,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [REG_DATA_WIDTH-1:0]   wdata,
    input  logic [REG_DATA_WIDTH/8-1:0] wstrb,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [ADDRESS_WIDTH-1:0]    araddr,
    input  logic [2:0]                  arprot,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [REG_DATA_WIDTH-1:0]   rdata,
    output logic [1:0]                  rresp,
    output logic                        rvalid,
    input  logic                        rready,
    output logic [7:0]                  err_count
);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int STRB_W = REG_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] WAIT_INIT   = 4'(READ_WAIT);

    typedef enum logic [1:0] {WR_IDLE, WAIT_W, WAIT_AW, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_WAIT, RD_DATA} rd_state_t;

    // Protection bits and the byte offset within a word carry no meaning for this memory.
    logic unused_ok;
    assign unused_ok = &{1'b0, awprot, arprot, awaddr[1:0], araddr[1:0]};

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] addr);
        return (addr >> (IDX_W + 2)) == '0;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDRESS_WIDTH-1:0] addr);
        return addr[IDX_W+1:2];
    endfunction

    logic [REG_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // ---------------- write channel ----------------
    wr_state_t                 wr_state;
    logic [ADDRESS_WIDTH-1:0]  aw_addr_q;
    logic [REG_DATA_WIDTH-1:0] w_data_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic                      aw_fire, w_fire, wr_commit;
    logic [ADDRESS_WIDTH-1:0]  wr_addr;
    logic [REG_DATA_WIDTH-1:0] wr_data;
    logic [STRB_W-1:0]         wr_strb;

    assign awready = (wr_state == WR_IDLE) || (wr_state == WAIT_AW);
    assign wready  = (wr_state == WR_IDLE) || (wr_state == WAIT_W);
    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;

    // Select the address/data of the write that completes this cycle: live or previously held.
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        wr_commit = 1'b0;
        wr_addr   = awaddr;
        wr_data   = wdata;
        wr_strb   = wstrb;
        unique case (wr_state)
            WR_IDLE: wr_commit = aw_fire && w_fire;
            WAIT_W: begin
                wr_commit = w_fire;
                wr_addr   = aw_addr_q;
            end
            WAIT_AW: begin
                wr_commit = aw_fire;
                wr_data   = w_data_q;
                wr_strb   = w_strb_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
        if (!axi4_lite_aresetn) begin
            wr_state  <= WR_IDLE;
            bvalid    <= 1'b0;
            bresp     <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            unique case (wr_state)
                WR_IDLE: begin
                    if (wr_commit) begin
                        wr_state <= WR_RESP;
                    end else if (aw_fire) begin
                        wr_state  <= WAIT_W;
                        aw_addr_q <= awaddr;
                    end else if (w_fire) begin
                        wr_state <= WAIT_AW;
                        w_data_q <= wdata;
                        w_strb_q <= wstrb;
                    end
                end
                WAIT_W, WAIT_AW: if (wr_commit) wr_state <= WR_RESP;
                WR_RESP: begin
                    if (bready) begin
                        wr_state <= WR_IDLE;
                        bvalid   <= 1'b0;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
            if (wr_commit) begin
                bvalid <= 1'b1;
                bresp  <= in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    // NOTE: the RAM array has no reset so it can map onto block memory; only control state is reset.
    always_ff @(posedge axi4_lite_aclk) begin
        if (wr_commit && in_range(wr_addr)) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (wr_strb[i]) mem[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rd_state_t                rd_state;
    logic [3:0]               wait_cnt;
    logic [ADDRESS_WIDTH-1:0] ar_addr_q;
    logic                     ar_fire, rd_sample;
    logic [ADDRESS_WIDTH-1:0] rd_addr;

    assign arready = (rd_state == RD_IDLE);
    assign ar_fire = arvalid && arready;

    always_comb begin
        rd_sample = 1'b0;
        rd_addr   = ar_addr_q;
        unique case (rd_state)
            RD_IDLE: begin
                if (READ_WAIT == 0) begin
                    rd_sample = ar_fire;
                    rd_addr   = araddr;
                end
            end
            RD_WAIT: rd_sample = (wait_cnt == 4'd1);
            default: ;
        endcase
    end

    // The RAM is sampled with the pre-edge contents, so a same-edge write is not visible (read-before-write).
    always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
        if (!axi4_lite_aresetn) begin
            rd_state  <= RD_IDLE;
            wait_cnt  <= '0;
            ar_addr_q <= '0;
            rvalid    <= 1'b0;
            rresp     <= RESP_OKAY;
            rdata     <= '0;
        end else begin
            unique case (rd_state)
                RD_IDLE: begin
                    if (ar_fire) begin
                        ar_addr_q <= araddr;
                        wait_cnt  <= WAIT_INIT;
                        if (READ_WAIT == 0) rd_state <= RD_DATA;
                        else                rd_state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (rd_sample) rd_state <= RD_DATA;
                end
                RD_DATA: begin
                    if (rready) begin
                        rd_state <= RD_IDLE;
                        rvalid   <= 1'b0;
                        rdata    <= '0;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
            if (rd_sample) begin
                rvalid <= 1'b1;
                rresp  <= in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
                rdata  <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
            end
        end
    end

    // ---------------- error counter ----------------
    logic [1:0] err_inc;
    logic [8:0] err_sum;

    assign err_inc = {1'b0, wr_commit && !in_range(wr_addr)} + {1'b0, rd_sample && !in_range(rd_addr)};
    assign err_sum = {1'b0, err_count} + {7'b0, err_inc};

    always_ff @(posedge axi4_lite_aclk or negedge axi4_lite_aresetn) begin
        if (!axi4_lite_aresetn) err_count <= '0;
        else                    err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end

endmodule
